// File: rtl/control_contador.sv
// control_contador: sequences clear, prescaled enables and completion for an 8-bit up-counter
module control_contador #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [7:0]         cfg_limit,
    input  logic [PRESC_W-1:0] cfg_presc,
    input  logic               cfg_reload,
    input  logic               start,
    input  logic               stop,
    input  logic [7:0]         cnt_value,
    input  logic               cnt_cout,
    output logic               cnt_enable,
    output logic               cnt_clr_n,
    output logic               busy,
    output logic               done,
    output logic               overflow_err
);
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        CLEAR = 4'b0010,
        RUN   = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    state_t             state, state_next;
    logic [7:0]         limit_reg;
    logic [PRESC_W-1:0] presc_reg, presc_cnt;
    logic               reload_reg;
    logic               at_limit, accept;

    assign at_limit = cnt_value == limit_reg;
    assign accept   = cfg_valid && cfg_ready;

    // next state and control outputs; stop overrides everything except the done pulse
    always_comb begin
        state_next = state;
        cfg_ready  = state == IDLE;
        busy       = state != IDLE;
        done       = state == DONE;
        cnt_enable = state == RUN && presc_cnt == presc_reg && !at_limit && !stop;
        case (state)
            IDLE:    state_next = start ? CLEAR : IDLE;
            CLEAR:   state_next = stop ? IDLE : RUN;
            RUN:     state_next = stop ? IDLE : (at_limit ? DONE : RUN);
            DONE:    state_next = (reload_reg && !stop) ? CLEAR : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // state register; clear is registered from next state so it comes straight off a flop
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt_clr_n <= 1'b1;
        end else begin
            state     <= state_next;
            cnt_clr_n <= state_next != CLEAR;
        end
    end

    // configuration latch, taken only while idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            limit_reg  <= 8'hFF;
            presc_reg  <= '0;
            reload_reg <= 1'b0;
        end else if (accept) begin
            limit_reg  <= cfg_limit;
            presc_reg  <= cfg_presc;
            reload_reg <= cfg_reload;
        end
    end

    // prescaler restarts on clear and after every issued enable
    always_ff @(posedge clk) begin
        if (!rst)
            presc_cnt <= '0;
        else if (state == CLEAR || cnt_enable)
            presc_cnt <= '0;
        else if (state == RUN)
            presc_cnt <= presc_cnt + 1'b1;
    end

    // sticky carry flag, cleared by a newly accepted configuration
    always_ff @(posedge clk) begin
        if (!rst)
            overflow_err <= 1'b0;
        else if (accept)
            overflow_err <= 1'b0;
        else if (busy && cnt_cout)
            overflow_err <= 1'b1;
    end
endmodule

// File: tb/tb_control_contador.sv
// tb_control_contador: directed vectors and corner sequences against a behavioural counter
module tb_control_contador;
    logic       clk = 0;
    logic       rst, cfg_valid, cfg_reload, start, stop, cout_force;
    logic [7:0] cfg_limit, cfg_presc, cnt;
    logic       cfg_ready, cnt_enable, cnt_clr_n, busy, done, overflow_err, cnt_cout;
    logic [31:0] en_m, done_m, clr_m, busy_m, ready_m, ovf_m;
    int tests = 0, fails = 0;

    typedef struct {
        logic [7:0]  l;
        logic [7:0]  p;
        int          d;
        logic [31:0] en;
    } vec_t;
    vec_t v[5];

    control_contador #(.PRESC_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_limit(cfg_limit), .cfg_presc(cfg_presc), .cfg_reload(cfg_reload),
        .start(start), .stop(stop), .cnt_value(cnt), .cnt_cout(cnt_cout),
        .cnt_enable(cnt_enable), .cnt_clr_n(cnt_clr_n), .busy(busy), .done(done),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    assign cnt_cout = cout_force | (cnt_enable && cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (!rst || !cnt_clr_n)
            cnt <= 8'd0;
        else if (cnt_enable)
            cnt <= cnt + 8'd1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic begin_run(input logic [7:0] l, input logic [7:0] p, input logic r, input bit together);
        cfg_limit  = l;
        cfg_presc  = p;
        cfg_reload = r;
        if (!together) begin
            cfg_valid = 1;
            @(posedge clk); #1;
        end
        cfg_valid = together;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        cfg_valid = 0;
    endtask

    task automatic run_cycles(input int n, input int stop_at, input int cout_at, input int cfg_at);
        en_m = 0; done_m = 0; clr_m = 0; busy_m = 0; ready_m = 0; ovf_m = 0;
        for (int c = 1; c <= n; c++) begin
            stop = c == stop_at;
            cout_force = c == cout_at;
            cfg_valid = c == cfg_at;
            if (c == cfg_at) cfg_limit = 8'd9;
            #1;
            en_m[c]    = cnt_enable;
            done_m[c]  = done;
            clr_m[c]   = !cnt_clr_n;
            busy_m[c]  = busy;
            ready_m[c] = cfg_ready;
            ovf_m[c]   = overflow_err;
            @(posedge clk); #1;
        end
        stop = 0; cout_force = 0; cfg_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        v[0] = '{8'd3, 8'd0, 6,  32'h0000_001C};
        v[1] = '{8'd2, 8'd1, 7,  32'h0000_0028};
        v[2] = '{8'd0, 8'd5, 3,  32'h0000_0000};
        v[3] = '{8'd4, 8'd2, 15, 32'h0000_2490};
        v[4] = '{8'd1, 8'd3, 7,  32'h0000_0020};
        rst = 0; cfg_valid = 0; cfg_reload = 0; start = 0; stop = 0; cout_force = 0;
        cfg_limit = 0; cfg_presc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {26'd0, cfg_ready, busy, cnt_enable, cnt_clr_n, done, overflow_err}, 32'b100100);
        rst = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            begin_run(v[i].l, v[i].p, 1'b0, 1'b0);
            run_cycles(24, 0, 0, 0);
            chk($sformatf("v%0d_clr", i), clr_m, 32'h2);
            chk($sformatf("v%0d_enable", i), en_m, v[i].en);
            chk($sformatf("v%0d_done", i), done_m, 32'd1 << v[i].d);
            chk($sformatf("v%0d_busy", i), busy_m, ((32'd1 << (v[i].d + 1)) - 32'd1) & ~32'd1);
            chk($sformatf("v%0d_ready_after", i), {31'd0, ready_m[v[i].d + 1]}, 32'd1);
            chk($sformatf("v%0d_final_count", i), {24'd0, cnt}, {24'd0, v[i].l});
        end

        begin_run(8'd1, 8'd0, 1'b1, 1'b0);
        run_cycles(16, 9, 0, 0);
        chk("reload_done", done_m, 32'h0000_0110);
        chk("reload_enable", en_m, 32'h0000_0044);
        chk("reload_busy_after_stop", {25'd0, busy_m[16:10]}, 32'd0);
        chk("reload_ready_after_stop", {31'd0, ready_m[10]}, 32'd1);
        chk("reload_count", {24'd0, cnt}, 32'd0);

        begin_run(8'd4, 8'd0, 1'b0, 1'b1);
        run_cycles(12, 0, 0, 3);
        chk("same_cycle_done", done_m, 32'h0000_0080);
        chk("same_cycle_enable", en_m, 32'h0000_003C);
        chk("cfg_ready_in_run", {31'd0, ready_m[3]}, 32'd0);
        chk("same_cycle_count", {24'd0, cnt}, 32'd4);

        begin_run(8'd3, 8'd0, 1'b0, 1'b0);
        run_cycles(12, 3, 0, 0);
        chk("stop_run_enable", en_m, 32'h0000_0004);
        chk("stop_run_done", done_m, 32'd0);
        chk("stop_run_busy", {23'd0, busy_m[12:4]}, 32'd0);
        chk("stop_run_count", {24'd0, cnt}, 32'd1);

        begin_run(8'd5, 8'd0, 1'b0, 1'b0);
        run_cycles(10, 0, 3, 0);
        chk("ovf_sticky", ovf_m, 32'h0000_07F0);
        chk("ovf_done", done_m, 32'h0000_0100);
        cfg_limit = 8'd6; cfg_valid = 1;
        @(posedge clk); #1;
        cfg_valid = 0;
        chk("ovf_cleared_by_cfg", {31'd0, overflow_err}, 32'd0);
        begin_run(8'd6, 8'd0, 1'b0, 1'b1);
        run_cycles(4, 0, 3, 0);
        chk("ovf_set_again", {31'd0, ovf_m[4]}, 32'd1);
        chk("busy_before_reset", {31'd0, busy_m[4]}, 32'd1);
        rst = 0;
        @(posedge clk); #1;
        chk("mid_run_reset", {26'd0, busy, cnt_enable, overflow_err, cfg_ready, cnt_clr_n, done}, 32'b000110);
        chk("mid_run_reset_count", {24'd0, cnt}, 32'd0);
        rst = 1;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
